// File: rtl/spi_pkg.sv
// Shared constants and FSM state type for the SPI slave.
package spi_pkg;

    localparam int unsigned DATA_W_DEF      = 8;
    localparam int unsigned SYNC_STAGES_DEF = 2;

    typedef enum logic [0:0] {
        StIdle  = 1'b0,
        StShift = 1'b1
    } state_e;

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchronizer for one asynchronous input, with a programmable reset level.
module spi_sync #(
    parameter int unsigned STAGES  = 2,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= {STAGES{RST_VAL}};
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/spi_slave.sv
// Mode-0 SPI slave: synchronized sclk/cs_n/mosi, MSB-first shifting, one-entry tx buffer,
// rx word register with valid pulse, and tx underrun reporting.
module spi_slave
    import spi_pkg::*;
#(
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              tx_underrun,
    output logic              busy
);

    localparam int unsigned       CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(DATA_W - 1);

    logic w_sclk_s, w_cs_n_s, w_mosi_s;
    logic r_sclk_prev, r_cs_n_prev;
    logic [SYNC_STAGES-1:0] r_flush;
    logic r_cs_ok;

    state_e r_state, w_state_next;

    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_rx_sr, r_tx_sr, r_tx_buf, r_rx_data;
    logic              r_buf_full, r_rx_valid, r_underrun;

    logic w_sclk_rise, w_sclk_fall, w_cs_fall, w_cs_rise;
    logic w_active, w_wrap, w_word_start, w_tx_hs;

    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk (clk),
        .rst (rst),
        .i_d (sclk),
        .o_q (w_sclk_s)
    );

    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs_n (
        .clk (clk),
        .rst (rst),
        .i_d (cs_n),
        .o_q (w_cs_n_s)
    );

    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk (clk),
        .rst (rst),
        .i_d (mosi),
        .o_q (w_mosi_s)
    );

    assign w_sclk_rise = w_sclk_s & ~r_sclk_prev;
    assign w_sclk_fall = ~w_sclk_s & r_sclk_prev;
    // A fall only counts once cs_n has been seen high after the synchronizers flushed,
    // so a cs_n held low across reset release cannot start a word.
    assign w_cs_fall   = r_cs_ok & r_cs_n_prev & ~w_cs_n_s;
    assign w_cs_rise   = ~r_cs_n_prev & w_cs_n_s;

    assign w_active     = (r_state == StShift) && !w_cs_rise;
    assign w_wrap       = w_active && w_sclk_rise && (r_cnt == LAST);
    assign w_word_start = ((r_state == StIdle) && w_cs_fall) || w_wrap;
    assign w_tx_hs      = tx_valid && !r_buf_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (w_cs_fall) w_state_next = StShift;
            StShift: if (w_cs_rise) w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sclk_prev <= 1'b0;
            r_cs_n_prev <= 1'b1;
            r_flush     <= '0;
            r_cs_ok     <= 1'b0;
            r_cnt       <= '0;
            r_rx_sr     <= '0;
            r_tx_sr     <= '0;
            r_tx_buf    <= '0;
            r_rx_data   <= '0;
            r_buf_full  <= 1'b0;
            r_rx_valid  <= 1'b0;
            r_underrun  <= 1'b0;
        end else begin
            r_sclk_prev <= w_sclk_s;
            r_cs_n_prev <= w_cs_n_s;
            r_flush     <= {r_flush[SYNC_STAGES-2:0], 1'b1};
            if (r_flush[SYNC_STAGES-1] && w_cs_n_s) begin
                r_cs_ok <= 1'b1;
            end
            r_rx_valid <= 1'b0;
            r_underrun <= 1'b0;

            // A same-cycle handshake refills the buffer after the word start drained it.
            if (w_tx_hs) begin
                r_tx_buf   <= tx_data;
                r_buf_full <= 1'b1;
            end else if (w_word_start) begin
                r_buf_full <= 1'b0;
            end

            // No shift on the fall right after a wrap: the new word's MSB must stay on miso.
            if (w_word_start) begin
                r_tx_sr    <= r_buf_full ? r_tx_buf : '0;
                r_underrun <= ~r_buf_full;
            end else if (w_active && w_sclk_fall && (r_cnt != '0)) begin
                r_tx_sr <= r_tx_sr << 1;
            end

            if (w_active && w_sclk_rise) begin
                r_rx_sr <= {r_rx_sr[DATA_W-2:0], w_mosi_s};
                if (w_wrap) begin
                    r_cnt      <= '0;
                    r_rx_data  <= {r_rx_sr[DATA_W-2:0], w_mosi_s};
                    r_rx_valid <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else if (!w_active) begin
                r_cnt   <= '0;
                r_rx_sr <= '0;
            end
        end
    end

    assign busy        = (r_state == StShift);
    assign miso        = busy ? r_tx_sr[DATA_W-1] : 1'b0;
    assign miso_oe     = busy;
    assign tx_ready    = ~r_buf_full;
    assign rx_data     = r_rx_data;
    assign rx_valid    = r_rx_valid;
    assign tx_underrun = r_underrun;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a mode-0 initiator model driven from one initial block.
module tb_spi_slave;

    localparam int HALF = 6;  // sclk half period in clk cycles

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sclk = 1'b0;
    logic       cs_n = 1'b1;
    logic       mosi = 1'b0;
    logic       miso, miso_oe, tx_ready, rx_valid, tx_underrun, busy;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic [7:0] rx_data;

    int errors = 0;
    int checks = 0;
    int n_rxv = 0;
    int n_und = 0;
    int und_snap = 0;

    spi_slave dut (
        .clk         (clk),
        .rst         (rst),
        .sclk        (sclk),
        .cs_n        (cs_n),
        .mosi        (mosi),
        .miso        (miso),
        .miso_oe     (miso_oe),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .tx_underrun (tx_underrun),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid) n_rxv <= n_rxv + 1;
        if (tx_underrun) n_und <= n_und + 1;
    end

    initial begin
        #1ms;
        $display("FAIL timeout: simulation did not finish within the time limit");
        $fatal(1, "timeout");
    end

    task automatic push(input logic [7:0] d);
        int n = 0;
        @(negedge clk);
        while (!tx_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!tx_ready) begin
            errors++;
            $display("FAIL push_wait: tx_ready=%b required 1", tx_ready);
        end
        tx_data = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic cs_low();
        cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic cs_high();
        repeat (HALF) @(negedge clk);
        cs_n = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    // Shift n bits MSB first; miso is sampled at each sclk rise.
    task automatic spi_bits(input int n, input logic [7:0] mo, output logic [7:0] mi);
        mi = 8'h00;
        for (int i = 0; i < n; i++) begin
            mosi = mo[7-i];
            repeat (HALF) @(negedge clk);
            if (i == n - 1) und_snap = n_und;
            sclk = 1'b1;
            mi = {mi[6:0], miso};
            repeat (HALF) @(negedge clk);
            sclk = 1'b0;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s_busy: got %b want 0", tag, busy); end
        checks++; if (miso !== 1'b0) begin errors++; $display("FAIL %s_miso: got %b want 0", tag, miso); end
        checks++; if (miso_oe !== 1'b0) begin errors++; $display("FAIL %s_oe: got %b want 0", tag, miso_oe); end
        checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL %s_txrdy: got %b want 1", tag, tx_ready); end
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL %s_rxdata: got %h want 00", tag, rx_data); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL %s_rxv: got %b want 0", tag, rx_valid); end
        checks++; if (tx_underrun !== 1'b0) begin errors++; $display("FAIL %s_und: got %b want 0", tag, tx_underrun); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (4) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_basic();
        logic [7:0] mi;
        int rxv0;
        push(8'hA5);
        checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL basic_full: tx_ready=%b want 0", tx_ready); end
        rxv0 = n_rxv;
        cs_low();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b want 1", busy); end
        checks++; if (miso_oe !== 1'b1) begin errors++; $display("FAIL basic_oe: got %b want 1", miso_oe); end
        checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL basic_txrdy: got %b want 1", tx_ready); end
        spi_bits(8, 8'h3C, mi);
        checks++; if (mi !== 8'hA5) begin errors++; $display("FAIL basic_miso: got %h want a5", mi); end
        cs_high();
        checks++; if (rx_data !== 8'h3C) begin errors++; $display("FAIL basic_rx: got %h want 3c", rx_data); end
        checks++; if (n_rxv - rxv0 !== 1) begin errors++; $display("FAIL basic_rxv: got %0d want 1", n_rxv - rxv0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_idle: busy=%b want 0", busy); end
    endtask

    task automatic test_underrun();
        logic [7:0] mi;
        int und0;
        und0 = n_und;
        cs_low();
        checks++; if (n_und - und0 !== 1) begin errors++; $display("FAIL und_start: got %0d want 1", n_und - und0); end
        spi_bits(8, 8'hFF, mi);
        checks++; if (mi !== 8'h00) begin errors++; $display("FAIL und_miso: got %h want 00", mi); end
        checks++; if (und_snap - und0 !== 1) begin errors++; $display("FAIL und_count: got %0d want 1", und_snap - und0); end
        cs_high();
        checks++; if (rx_data !== 8'hFF) begin errors++; $display("FAIL und_rx: got %h want ff", rx_data); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] mi;
        int und0, rxv0;
        push(8'h12);
        und0 = n_und;
        rxv0 = n_rxv;
        cs_low();
        push(8'h34);
        spi_bits(8, 8'hC3, mi);
        checks++; if (mi !== 8'h12) begin errors++; $display("FAIL b2b_miso0: got %h want 12", mi); end
        checks++; if (rx_data !== 8'hC3) begin errors++; $display("FAIL b2b_rx0: got %h want c3", rx_data); end
        spi_bits(8, 8'h5A, mi);
        checks++; if (mi !== 8'h34) begin errors++; $display("FAIL b2b_miso1: got %h want 34", mi); end
        checks++; if (und_snap - und0 !== 0) begin errors++; $display("FAIL b2b_und: got %0d want 0", und_snap - und0); end
        cs_high();
        checks++; if (rx_data !== 8'h5A) begin errors++; $display("FAIL b2b_rx1: got %h want 5a", rx_data); end
        checks++; if (n_rxv - rxv0 !== 2) begin errors++; $display("FAIL b2b_rxv: got %0d want 2", n_rxv - rxv0); end
    endtask

    task automatic test_abort();
        logic [7:0] mi;
        int rxv0;
        rxv0 = n_rxv;
        cs_low();
        spi_bits(5, 8'hF0, mi);
        cs_high();
        checks++; if (n_rxv - rxv0 !== 0) begin errors++; $display("FAIL abort_rxv: got %0d want 0", n_rxv - rxv0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
        checks++; if (rx_data !== 8'h5A) begin errors++; $display("FAIL abort_hold: got %h want 5a", rx_data); end
        push(8'h7E);
        cs_low();
        spi_bits(8, 8'h81, mi);
        checks++; if (mi !== 8'h7E) begin errors++; $display("FAIL abort_miso: got %h want 7e", mi); end
        cs_high();
        checks++; if (rx_data !== 8'h81) begin errors++; $display("FAIL abort_rx: got %h want 81", rx_data); end
        checks++; if (n_rxv - rxv0 !== 1) begin errors++; $display("FAIL abort_rxv2: got %0d want 1", n_rxv - rxv0); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] mi;
        int rxv0;
        push(8'h55);
        rxv0 = n_rxv;
        cs_low();
        spi_bits(3, 8'hE0, mi);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("rstmid");
        rst = 1'b0;
        // cs_n still low: no word may start until a fresh falling edge
        repeat (20) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_wait: busy=%b want 0", busy); end
        checks++; if (n_rxv - rxv0 !== 0) begin errors++; $display("FAIL rstmid_rxv: got %0d want 0", n_rxv - rxv0); end
        cs_n = 1'b1;
        repeat (HALF) @(negedge clk);
        push(8'h66);
        cs_low();
        spi_bits(8, 8'h66, mi);
        checks++; if (mi !== 8'h66) begin errors++; $display("FAIL rstmid_miso: got %h want 66", mi); end
        cs_high();
        checks++; if (rx_data !== 8'h66) begin errors++; $display("FAIL rstmid_rx: got %h want 66", rx_data); end
    endtask

    task automatic test_same_cycle();
        logic [7:0] mi;
        // Word start lands on the third clk edge after cs_n drops (two sync flops + edge detect).
        cs_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL same_rdy: got %b want 1", tx_ready); end
        tx_data = 8'h99;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        checks++; if (tx_underrun !== 1'b1) begin errors++; $display("FAIL same_und: got %b want 1", tx_underrun); end
        checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL same_held: tx_ready=%b want 0", tx_ready); end
        repeat (HALF) @(negedge clk);
        spi_bits(8, 8'h00, mi);
        checks++; if (mi !== 8'h00) begin errors++; $display("FAIL same_miso0: got %h want 00", mi); end
        spi_bits(8, 8'h00, mi);
        checks++; if (mi !== 8'h99) begin errors++; $display("FAIL same_miso1: got %h want 99", mi); end
        cs_high();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_underrun();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        test_same_cycle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning bits per SPI word (MSB first).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning flip-flop depth of the input synchronizers (minimum 2).
REQ-003 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port sclk  input  1  SPI clock from the initiator, asynchronous to clk; mode 0 (CPOL=0, CPHA=0).
REQ-006 SHALL have port cs_n  input  1  active-low chip select, asynchronous to clk.
REQ-007 SHALL have port mosi  input  1  serial data from the initiator.
REQ-008 SHALL have port miso  output  1  serial data to the initiator.
REQ-009 SHALL have port miso_oe  output  1  miso output enable; high only while selected.
REQ-010 SHALL have port tx_data  input  DATA_W  word to transmit next.
REQ-011 SHALL have port tx_valid  input  1  tx_data valid.
REQ-012 SHALL have port tx_ready  output  1  one-entry tx buffer empty; the word transfers when tx_valid and tx_ready are both high on a clk edge.
REQ-013 SHALL have port rx_data  output  DATA_W  last complete received word; held until the next word completes.
REQ-014 SHALL have port rx_valid  output  1  one-cycle pulse when rx_data updates.
REQ-015 SHALL have port tx_underrun  output  1  one-cycle pulse when a word starts with the tx buffer empty.
REQ-016 SHALL have port busy  output  1  high while the FSM is in SHIFT.

Function
REQ-017 SHALL pass sclk, cs_n and mosi through SYNC_STAGES synchronizers, and detect sclk edges from the last two synchronized samples.
REQ-018 SHALL operate correctly when the sclk frequency is at most the clk frequency divided by 8.
REQ-019 SHALL implement FSM states IDLE and SHIFT, where IDLE goes to SHIFT on a synchronized cs_n falling edge, and SHIFT goes to IDLE on a synchronized cs_n rising edge.
REQ-020 SHALL, on each word start, load the tx shift register from the tx buffer and mark the buffer empty; word start is the IDLE to SHIFT transition, or a bit count wrap while cs_n is still low.
REQ-021 SHALL, on a word start with the buffer empty, load all zeros and pulse tx_underrun for one cycle.
REQ-022 SHALL, on a synchronized sclk rising edge in SHIFT, shift the synchronized mosi into the rx shift register LSB and increment the bit counter.
REQ-023 SHALL, on a synchronized sclk falling edge in SHIFT, shift the tx register left so that the next bit appears on miso.
REQ-024 SHALL drive miso from the tx register MSB whenever busy, drive miso=0 otherwise, and set miso_oe equal to busy.
REQ-025 SHALL, when the bit counter reaches DATA_W on a rising edge, copy the rx shift register to rx_data, pulse rx_valid the following cycle, wrap the counter to 0 and start the next word (REQ-020).
REQ-026 SHALL, when cs_n rises mid-word, discard the partial word, produce no rx_valid pulse, and leave the tx buffer unchanged.
REQ-027 SHALL, when a tx handshake and a buffer-empty word start occur in the same cycle, send zeros for the current word, pulse tx_underrun, and hold the accepted word for the next word start.
REQ-028 SHALL ignore sclk edges while in IDLE.

Reset
REQ-029 SHALL, while rst is high, set the FSM to IDLE, the counter and shift registers to 0, rx_data=0, rx_valid=0, tx_underrun=0, busy=0, miso=0, miso_oe=0, tx_ready=1, and the synchronizers to idle levels (sclk=0, cs_n=1, mosi=0).
REQ-030 SHALL, when rst asserts mid-word, abandon the word with no rx_valid pulse; after release, the block waits for a fresh cs_n falling edge.

Structure
REQ-031 SHALL keep the FSM state enum and the default DATA_W and SYNC_STAGES constants in the shared package spi_pkg.
REQ-032 SHALL use one sub-module, spi_sync (a parameterized multi-flop synchronizer with reset value), instantiated once each for sclk, cs_n and mosi.

Verification
REQ-033 SHALL cover: preload tx_data=8'hA5, initiator sends 8'h3C in mode 0 -> initiator receives 8'hA5, rx_data=8'h3C, exactly one rx_valid pulse, tx_ready returns 1 at word start.
REQ-034 SHALL cover: no tx preload, initiator sends 8'hFF -> miso stays 0 for all 8 bits, one tx_underrun pulse, rx_data=8'hFF.
REQ-035 SHALL cover: two back-to-back words with cs_n held low, tx 8'h12 then 8'h34 (second loaded during the first), mosi 8'hC3 then 8'h5A -> the initiator gets 8'h12 then 8'h34, two rx_valid pulses, no underrun.
REQ-036 SHALL cover: cs_n released after 5 sclk cycles -> no rx_valid, busy=0, and a following full word 8'h81 is received correctly.
REQ-037 SHALL cover: rst pulsed after 3 bits of a word -> all outputs at reset values (REQ-029); the next frame exchanges 8'h66 correctly.
REQ-038 SHALL cover: tx_valid asserted in the same cycle as an empty-buffer word start (tx_data=8'h99) -> current word sends 8'h00, and the next word sends 8'h99.
